// File: rtl/max_pool2.sv
// 2x2 / stride-2 signed int8 max pooling over a CH x IN_W x IN_W map in RAM_1.
// Writes CH x (IN_W/2) x (IN_W/2) results into RAM_0 through single-port read/write strobes.
module max_pool2 #(
  parameter int          IN_W     = 22,
  parameter int          CH       = 12,
  parameter logic [15:0] SRC_BASE = 16'h8000,
  parameter logic [15:0] DST_BASE = 16'h0000,
  parameter int          RD_LAT   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_MaxPool2,
  output logic              end_MaxPool2,
  output logic [15:0]       ram_addr_r,
  output logic              ram_en_r,
  input  logic signed [7:0] ram_data_r,
  output logic [15:0]       ram_addr_w,
  output logic signed [7:0] ram_data_w,
  output logic              ram_en,
  output logic              ram_wea
);

  localparam int OUT_W = IN_W / 2;
  localparam int XW    = $clog2(OUT_W + 1);
  localparam int CW    = $clog2(CH + 1);

  localparam logic [XW-1:0] X_LAST    = XW'(OUT_W - 1);
  localparam logic [CW-1:0] C_LAST    = CW'(CH - 1);
  localparam logic [2:0]    K_RD      = 3'(RD_LAT);
  localparam logic [2:0]    K_LAST    = 3'(RD_LAT + 3);
  localparam logic [15:0]   IN_W16    = 16'(IN_W);
  localparam logic [15:0]   OUT_W16   = 16'(OUT_W);
  localparam logic [15:0]   IN_PLANE  = 16'(IN_W * IN_W);
  localparam logic [15:0]   OUT_PLANE = 16'(OUT_W * OUT_W);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t            state, state_d;
  logic [2:0]        k, k_d, k_nxt;
  logic [1:0]        done_cnt, done_cnt_d;
  logic [XW-1:0]     ox, oy, ox_d, oy_d, nx, ny;
  logic [CW-1:0]     c, c_d, nc;
  logic              last_out;
  logic signed [7:0] run_max, run_max_d, sample_max;

  logic [15:0]       addr_r_d, addr_w_d;
  logic signed [7:0] data_w_d;
  logic              en_r_d, wr_d, end_d;

  // Window element e: bit 0 selects x offset, bit 1 selects y offset.
  function automatic logic [15:0] src_addr(input logic [XW-1:0] px, input logic [XW-1:0] py,
                                           input logic [CW-1:0] pc, input logic [1:0] e);
    logic [15:0] x, y;
    x = (16'(px) << 1) + 16'(e[0]);
    y = (16'(py) << 1) + 16'(e[1]);
    return SRC_BASE + x + y * IN_W16 + 16'(pc) * IN_PLANE;
  endfunction

  function automatic logic [15:0] dst_addr(input logic [XW-1:0] px, input logic [XW-1:0] py,
                                           input logic [CW-1:0] pc);
    return DST_BASE + 16'(px) + 16'(py) * OUT_W16 + 16'(pc) * OUT_PLANE;
  endfunction

  // Index advance: ox fastest, then oy, then c.
  always_comb begin
    nx       = ox + 1'b1;
    ny       = oy;
    nc       = c;
    last_out = 1'b0;
    if (ox == X_LAST) begin
      nx = '0;
      if (oy == X_LAST) begin
        ny = '0;
        if (c == C_LAST) begin
          nc       = '0;
          last_out = 1'b1;
        end else begin
          nc = c + 1'b1;
        end
      end else begin
        ny = oy + 1'b1;
      end
    end
  end

  // First sample loads; later samples replace only when strictly greater.
  assign sample_max = (k == K_RD || ram_data_r > run_max) ? ram_data_r : run_max;
  assign k_nxt      = k + 3'd1;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    state_d    = state;
    k_d        = k;
    done_cnt_d = done_cnt;
    ox_d       = ox;
    oy_d       = oy;
    c_d        = c;
    run_max_d  = run_max;
    addr_r_d   = ram_addr_r;
    en_r_d     = 1'b0;
    addr_w_d   = ram_addr_w;
    data_w_d   = ram_data_w;
    wr_d       = 1'b0;
    end_d      = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start_MaxPool2) begin
          state_d  = S_READ;
          k_d      = '0;
          ox_d     = '0;
          oy_d     = '0;
          c_d      = '0;
          en_r_d   = 1'b1;
          addr_r_d = src_addr('0, '0, '0, 2'd0);
        end
      end

      S_READ: begin
        if (k >= K_RD) run_max_d = sample_max;
        if (k == K_LAST) begin
          state_d  = S_WRITE;
          wr_d     = 1'b1;
          addr_w_d = dst_addr(ox, oy, c);
          data_w_d = sample_max;
        end else begin
          k_d = k_nxt;
          if (k_nxt < 3'd4) begin
            en_r_d   = 1'b1;
            addr_r_d = src_addr(ox, oy, c, k_nxt[1:0]);
          end
        end
      end

      S_WRITE: begin
        ox_d = nx;
        oy_d = ny;
        c_d  = nc;
        if (last_out) begin
          state_d    = S_DONE;
          done_cnt_d = '0;
          end_d      = 1'b1;
        end else begin
          state_d  = S_READ;
          k_d      = '0;
          en_r_d   = 1'b1;
          addr_r_d = src_addr(nx, ny, nc, 2'd0);
        end
      end

      S_DONE: begin
        if (done_cnt == 2'd3) begin
          state_d = S_IDLE;
        end else begin
          done_cnt_d = done_cnt + 2'd1;
          end_d      = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      k            <= '0;
      done_cnt     <= '0;
      ox           <= '0;
      oy           <= '0;
      c            <= '0;
      run_max      <= '0;
      ram_addr_r   <= '0;
      ram_en_r     <= 1'b0;
      ram_addr_w   <= '0;
      ram_data_w   <= '0;
      ram_en       <= 1'b0;
      ram_wea      <= 1'b0;
      end_MaxPool2 <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
      state        <= state_d;
      k            <= k_d;
      done_cnt     <= done_cnt_d;
      ox           <= ox_d;
      oy           <= oy_d;
      c            <= c_d;
      run_max      <= run_max_d;
      ram_addr_r   <= addr_r_d;
      ram_en_r     <= en_r_d;
      ram_addr_w   <= addr_w_d;
      ram_data_w   <= data_w_d;
      ram_en       <= wr_d;
      ram_wea      <= wr_d;
      end_MaxPool2 <= end_d;
    end
  end

endmodule

// File: tb/tb_max_pool2.sv
// Scoreboard bench for max_pool2: a RAM model feeds the DUT, a golden 2x2 max model fills the
// expected-write queue, and a negedge monitor pops and compares every write.
module tb_max_pool2;

  localparam int IN_W   = 22;
  localparam int CH     = 12;
  localparam int RD_LAT = 2;
  localparam int OUT_W  = IN_W / 2;
  localparam int N_OUT  = CH * OUT_W * OUT_W;
  localparam int N_IN   = CH * IN_W * IN_W;
  localparam int SRC    = 32'h8000;
  localparam int DST    = 32'h0000;
  localparam int PERIOD = 5 + RD_LAT;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_MaxPool2;
  logic              end_MaxPool2;
  logic [15:0]       ram_addr_r;
  logic              ram_en_r;
  logic signed [7:0] ram_data_r;
  logic [15:0]       ram_addr_w;
  logic signed [7:0] ram_data_w;
  logic              ram_en;
  logic              ram_wea;

  max_pool2 #(
    .IN_W(IN_W), .CH(CH), .SRC_BASE(16'h8000), .DST_BASE(16'h0000), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst), .start_MaxPool2(start_MaxPool2), .end_MaxPool2(end_MaxPool2),
    .ram_addr_r(ram_addr_r), .ram_en_r(ram_en_r), .ram_data_r(ram_data_r),
    .ram_addr_w(ram_addr_w), .ram_data_w(ram_data_w), .ram_en(ram_en), .ram_wea(ram_wea)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Source RAM with RD_LAT-deep read pipeline.
  logic signed [7:0] mem  [0:65535];
  logic signed [7:0] pipe [0:RD_LAT-1];
  always @(posedge clk) begin
    pipe[0] <= ram_en_r ? mem[ram_addr_r] : 8'sd0;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_data_r = pipe[RD_LAT-1];

  typedef struct {
    logic [15:0]       addr;
    logic signed [7:0] data;
  } wr_t;
  wr_t exp_q[$];
  wr_t got;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor state
  int write_cnt, read_cnt, end_rises, end_high, first_read_cyc, end_rise_cyc;
  bit seen_read, end_prev;

  always @(negedge clk) begin
    if (ram_en_r) begin
      read_cnt++;
      if (!seen_read) begin
        seen_read      = 1'b1;
        first_read_cyc = cyc;
      end
    end
    if (ram_en && ram_wea) begin
      write_cnt++;
      check("rd_wr_overlap", int'(ram_en_r), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_write", write_cnt, 0);
      end else begin
        got = exp_q.pop_front();
        check("wr_addr", int'(ram_addr_w), int'(got.addr));
        check("wr_data", int'(ram_data_w), int'(got.data));
      end
    end
    if (end_MaxPool2) begin
      end_high++;
      if (!end_prev) begin
        end_rises++;
        end_rise_cyc = cyc;
      end
    end
    end_prev = end_MaxPool2;
  end

  // Golden model: plain nested loops over the map, max of the four window values.
  task automatic build_expected();
    exp_q.delete();
    for (int ch = 0; ch < CH; ch++)
      for (int oy = 0; oy < OUT_W; oy++)
        for (int ox = 0; ox < OUT_W; ox++) begin
          int m;
          m = -1000;
          for (int e = 0; e < 4; e++) begin
            int x, y, v;
            x = 2 * ox + (e % 2);
            y = 2 * oy + (e / 2);
            v = int'(mem[(SRC + x + y * IN_W + ch * IN_W * IN_W) % 65536]);
            if (v > m) m = v;
          end
          exp_q.push_back('{addr: 16'(DST + ox + oy * OUT_W + ch * OUT_W * OUT_W), data: 8'(m)});
        end
  endtask

  task automatic set_window(input int ox, input int v0, input int v1, input int v2, input int v3);
    mem[SRC + 2 * ox]            = 8'(v0);
    mem[SRC + 2 * ox + 1]        = 8'(v1);
    mem[SRC + 2 * ox + IN_W]     = 8'(v2);
    mem[SRC + 2 * ox + IN_W + 1] = 8'(v3);
  endtask

  task automatic clear_monitor();
    write_cnt = 0;
    read_cnt  = 0;
    end_rises = 0;
    end_high  = 0;
    seen_read = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); #1;
    start_MaxPool2 = 1'b1;
    @(negedge clk); #1;
    start_MaxPool2 = 1'b0;
  endtask

  task automatic do_run(input string tag, input bit poke);
    int guard;
    build_expected();
    @(negedge clk); #1;
    clear_monitor();
    pulse_start();
    if (poke) begin
      repeat (3000) @(negedge clk);
      #1 start_MaxPool2 = 1'b1;
      @(negedge clk); #1 start_MaxPool2 = 1'b0;
    end
    guard = 0;
    while (end_rises == 0 && guard < N_OUT * PERIOD + 200) begin
      @(negedge clk); #1;
      guard++;
    end
    if (end_rises == 0) check({tag, "_end_timeout"}, 0, 1);
    if (poke) begin
      start_MaxPool2 = 1'b1;
      @(negedge clk); #1 start_MaxPool2 = 1'b0;
    end
    repeat (20) @(negedge clk);
    #1;
    check({tag, "_end_rises"}, end_rises, 1);
    check({tag, "_end_len"}, end_high, 4);
    check({tag, "_latency"}, end_rise_cyc - first_read_cyc, N_OUT * PERIOD);
    check({tag, "_writes"}, write_cnt, N_OUT);
    check({tag, "_reads"}, read_cnt, 4 * N_OUT);
    check({tag, "_leftover"}, exp_q.size(), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_end"}, int'(end_MaxPool2), 0);
    check({tag, "_addr_r"}, int'(ram_addr_r), 0);
    check({tag, "_en_r"}, int'(ram_en_r), 0);
    check({tag, "_addr_w"}, int'(ram_addr_w), 0);
    check({tag, "_data_w"}, int'(ram_data_w), 0);
    check({tag, "_en"}, int'(ram_en), 0);
    check({tag, "_wea"}, int'(ram_wea), 0);
  endtask

  initial begin
    int guard, saved;
    rst            = 1'b1;
    start_MaxPool2 = 1'b0;
    clear_monitor();
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    #1 rst = 1'b0;

    // Ramp, with start pulses mid-run and during DONE that must be ignored.
    for (int i = 0; i < N_IN; i++) mem[SRC + i] = 8'(i % 256);
    do_run("ramp", 1'b1);

    // All minimum values.
    for (int i = 0; i < N_IN; i++) mem[SRC + i] = -8'sd128;
    do_run("min", 1'b0);

    // Random map with directed windows along the first output row.
    for (int i = 0; i < N_IN; i++) mem[SRC + i] = 8'($urandom);
    set_window(0, 100, -1, -1, -1);
    set_window(1, -1, 100, -1, -1);
    set_window(2, -1, -1, 100, -1);
    set_window(3, -1, -1, -1, 100);
    set_window(4, -5, -3, -100, -7);
    set_window(5, 127, -128, 0, 0);
    do_run("rand", 1'b0);

    // Reset asserted during the 500th write aborts the run.
    for (int i = 0; i < N_IN; i++) mem[SRC + i] = 8'($urandom);
    build_expected();
    @(negedge clk); #1;
    clear_monitor();
    pulse_start();
    guard = 0;
    while (write_cnt < 500 && guard < 600 * PERIOD) begin
      @(negedge clk); #1;
      guard++;
    end
    check("abort_reached_500", write_cnt, 500);
    rst = 1'b1;
    @(negedge clk); #1;
    check_outputs_zero("abort");
    rst = 1'b0;
    exp_q.delete();
    saved    = write_cnt;
    read_cnt = 0;
    repeat (40) @(negedge clk);
    #1;
    check("abort_no_writes", write_cnt, saved);
    check("abort_idle_no_reads", read_cnt, 0);
    check("abort_no_end", end_rises, 0);

    // Full run after the abort.
    do_run("after_abort", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
